// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO transmitter and its bit counter.
package piso_pkg;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  localparam logic LR_LSB_FIRST  = 1'b1;
  localparam logic LR_MSB_FIRST  = 1'b0;
  localparam int   DEFAULT_WIDTH = 8;

endpackage

// File: rtl/tx_bit_counter.sv
// Frame bit counter: counts 0..FRAME_LEN-1 and flags the final bit cycle.
module tx_bit_counter #(
  parameter int FRAME_LEN = 8,
  parameter int CW        = $clog2(FRAME_LEN)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [CW-1:0] LastCnt = CW'(FRAME_LEN - 1);

  logic [CW-1:0] cnt_q;

  // Returning to zero after the last bit keeps the count in range even when FRAME_LEN is not a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i || (en_i && last_o)) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_o = (cnt_q == LastCnt);

endmodule

// File: rtl/shift_piso_tx.sv
// Parallel-in serial-out transmitter feeding a negedge-sampling SIPO; gapless back-to-back frames.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module shift_piso_tx
  import piso_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             lr,
  input  logic [WIDTH-1:0] d_in,
  output logic             s_out,
  output logic             ready,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int SW = FRAME_LEN;

  state_e        state_q;
  logic [SW-1:0] shreg_q;
  logic          dir_q;
  logic          done_q;
  logic [SW-1:0] load_word;
  logic          last;
  logic          accept;

  // The parity bit sits at the far end of the shift register so it leaves after the data in either direction.
`ifdef PISO_PARITY_EN
  assign load_word = (lr == LR_LSB_FIRST) ? {^d_in, d_in} : {d_in, ^d_in};
`else
  assign load_word = d_in;
`endif

  assign busy   = (state_q == ST_SHIFT);
  assign ready  = (state_q == ST_IDLE) || last;
  assign accept = start && ready;
  assign done   = done_q;
  assign s_out  = !busy ? IDLE_LEVEL :
                  (dir_q == LR_LSB_FIRST) ? shreg_q[0] : shreg_q[SW-1];

  tx_bit_counter #(
    .FRAME_LEN(FRAME_LEN)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (accept),
    .en_i  (busy),
    .last_o(last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shreg_q <= load_word;
            dir_q   <= lr;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (last) begin
            done_q <= 1'b1;
          end
          if (last && start) begin
            shreg_q <= load_word;
            dir_q   <= lr;
          end else begin
            shreg_q <= (dir_q == LR_LSB_FIRST) ? (shreg_q >> 1) : (shreg_q << 1);
            if (last) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
